// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: state encoding and shared constants for the pipeline stall controller
package pipe_stall_ctrl_pkg;
   typedef enum logic [1:0] {S_RUN = 2'd0, S_IMISS = 2'd1, S_ERR = 2'd2} state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between EX load and ID sources
module hazard_detect
   import pipe_stall_ctrl_pkg::*;
(
   input  logic       IDEX_MEMREAD,
   input  logic [4:0] IDEX_RT,
   input  logic [4:0] IFID_RS,
   input  logic [4:0] IFID_RT,
   output logic       LOAD_USE
);
   assign LOAD_USE = IDEX_MEMREAD && IDEX_RT != REG_ZERO && (IDEX_RT == IFID_RS || IDEX_RT == IFID_RT);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller for load-use, branch squash, I-miss refill and D-cache hold
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ICACHE_HIT,
   input  logic             ICACHE_READY,
   input  logic             DCACHE_STALL,
   input  logic             IDEX_MEMREAD,
   input  logic [4:0]       IDEX_RT,
   input  logic [4:0]       IFID_RS,
   input  logic [4:0]       IFID_RT,
   input  logic             BRANCH_TAKEN,
   output logic             PC_WRITE,
   output logic             IFID_WRITE,
   output logic             IF_FLUSH,
   output logic             IDEX_BUBBLE,
   output logic             PIPE_HOLD,
   output logic             ICACHE_REQ,
   output logic             ERR,
   output logic [CNT_W-1:0] STALL_CNT
);
   localparam int MW = $clog2(MISS_TIMEOUT + 1);
   localparam logic [MW-1:0] TO_LAST = MW'(MISS_TIMEOUT - 1);
   state_t st, nxt;
   logic [MW-1:0] miss_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic load_use, timeout;
   logic pc, ifid, flush, bub, hold, req, err;
   hazard_detect u_hazard (
      .IDEX_MEMREAD(IDEX_MEMREAD),
      .IDEX_RT     (IDEX_RT),
      .IFID_RS     (IFID_RS),
      .IFID_RT     (IFID_RT),
      .LOAD_USE    (load_use)
   );
   // miss_cnt holds the number of IMISS cycles already completed
   assign timeout = miss_cnt == TO_LAST;
   always_comb begin
      nxt = st;
      pc = 1'b0;
      ifid = 1'b0;
      flush = 1'b0;
      bub = 1'b0;
      hold = 1'b0;
      req = 1'b0;
      err = 1'b0;
      case (st)
         S_RUN:
            if (DCACHE_STALL) hold = 1'b1;
            else if (BRANCH_TAKEN) begin
               pc = 1'b1;
               ifid = 1'b1;
               flush = 1'b1;
            end else if (load_use) bub = 1'b1;
            else if (!ICACHE_HIT) begin
               bub = 1'b1;
               req = 1'b1;
               nxt = S_IMISS;
            end else begin
               pc = 1'b1;
               ifid = 1'b1;
            end
         S_IMISS: begin
            req = 1'b1;
            hold = DCACHE_STALL;
            bub = !DCACHE_STALL;
            nxt = DCACHE_STALL ? S_IMISS : ICACHE_READY ? S_RUN : timeout ? S_ERR : S_IMISS;
         end
         S_ERR: begin
            err = 1'b1;
            hold = 1'b1;
         end
         default: nxt = S_RUN;
      endcase
   end
   // reset gates every output low, dropping an in-flight refill request at once
   assign PC_WRITE    = RESET & pc;
   assign IFID_WRITE  = RESET & ifid;
   assign IF_FLUSH    = RESET & flush;
   assign IDEX_BUBBLE = RESET & bub;
   assign PIPE_HOLD   = RESET & hold;
   assign ICACHE_REQ  = RESET & req;
   assign ERR         = RESET & err;
   assign STALL_CNT   = stall_cnt;
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         st <= S_RUN;
         miss_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         st <= nxt;
         miss_cnt <= st != S_IMISS ? '0 : timeout ? miss_cnt : miss_cnt + 1'b1;
         stall_cnt <= (!PC_WRITE && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
      end
   end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: vector table plus directed multi-cycle sequences for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
   logic CLK = 1'b0, RESET = 1'b0;
   logic hit = 1'b1, ready = 1'b0, dstall = 1'b0, memread = 1'b0, branch = 1'b0;
   logic [4:0] xrt = '0, rs = '0, rt = '0;
   logic pc_w, ifid_w, flush, bub, hold, req, err;
   logic [3:0] cnt;
   int pass = 0, total = 0;
   typedef struct {
      logic ds, br, mr;
      logic [4:0] xrt, rs, rt;
      logic hit;
      logic [5:0] exp;
      logic nxt_pc;
   } vec_t;
   vec_t v[12];
   pipe_stall_ctrl #(.MISS_TIMEOUT(8), .CNT_W(4)) dut (
      .CLK(CLK), .RESET(RESET), .ICACHE_HIT(hit), .ICACHE_READY(ready),
      .DCACHE_STALL(dstall), .IDEX_MEMREAD(memread), .IDEX_RT(xrt),
      .IFID_RS(rs), .IFID_RT(rt), .BRANCH_TAKEN(branch),
      .PC_WRITE(pc_w), .IFID_WRITE(ifid_w), .IF_FLUSH(flush), .IDEX_BUBBLE(bub),
      .PIPE_HOLD(hold), .ICACHE_REQ(req), .ERR(err), .STALL_CNT(cnt)
   );
   always #5 CLK = ~CLK;
   function automatic logic [5:0] outs();
      return {pc_w, ifid_w, flush, bub, hold, req};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic neutral();
      hit = 1'b1; ready = 1'b0; dstall = 1'b0; memread = 1'b0; branch = 1'b0;
      xrt = '0; rs = '0; rt = '0;
   endtask
   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b0;
      neutral();
      #2;
      chk("reset_outs", {outs(), err}, 7'd0);
      chk("reset_cnt", cnt, 0);
      @(negedge CLK);
      RESET = 1'b1;
   endtask
   task automatic miss_entry();
      hit = 1'b0;
      @(negedge CLK);
      hit = 1'b1;
   endtask
   initial begin
      // exp = {PC_WRITE, IFID_WRITE, IF_FLUSH, IDEX_BUBBLE, PIPE_HOLD, ICACHE_REQ}
      v[0]  = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 6'b110000, 1};
      v[1]  = '{0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 6'b000100, 1};
      v[2]  = '{0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 6'b000100, 1};
      v[3]  = '{0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 6'b110000, 1};
      v[4]  = '{0, 0, 0, 5'd5, 5'd5, 5'd0, 1, 6'b110000, 1};
      v[5]  = '{0, 0, 1, 5'd5, 5'd6, 5'd4, 1, 6'b110000, 1};
      v[6]  = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000101, 0};
      v[7]  = '{0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111000, 1};
      v[8]  = '{0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 6'b111000, 1};
      v[9]  = '{1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 6'b000010, 1};
      v[10] = '{0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 6'b000100, 1};
      v[11] = '{1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 6'b000010, 1};
      for (int i = 0; i < 12; i++) begin
         do_reset();
         dstall = v[i].ds; branch = v[i].br; memread = v[i].mr;
         xrt = v[i].xrt; rs = v[i].rs; rt = v[i].rt; hit = v[i].hit;
         #2;
         chk($sformatf("vec%0d", i), outs(), v[i].exp);
         @(negedge CLK);
         neutral();
         #2;
         chk($sformatf("vec%0d_next_pc", i), pc_w, v[i].nxt_pc);
      end
      // miss at cycle 0, refill ready at cycle 4, retry in RUN at cycle 5
      do_reset();
      hit = 1'b0;
      for (int c = 0; c < 5; c++) begin
         ready = c == 4;
         #2;
         chk($sformatf("miss_req_c%0d", c), {req, pc_w, bub}, 3'b101);
         @(negedge CLK);
      end
      ready = 1'b0; hit = 1'b1;
      #2;
      chk("miss_c5_outs", {req, pc_w, ifid_w}, 3'b011);
      chk("miss_c5_cnt", cnt, 5);
      // D-cache hold during IMISS, and a masked branch
      do_reset();
      miss_entry();
      dstall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("imiss_dstall_c%0d", c), {pc_w, ifid_w, flush, bub, hold, req}, 6'b000011);
         @(negedge CLK);
      end
      dstall = 1'b0; branch = 1'b1;
      #2;
      chk("imiss_branch_masked", {flush, bub, req, pc_w}, 4'b0110);
      @(negedge CLK);
      branch = 1'b0; ready = 1'b1;
      @(negedge CLK);
      ready = 1'b0;
      #2;
      chk("imiss_return_run", {pc_w, req}, 2'b10);
      // timeout into sticky ERR, then cleared by reset
      do_reset();
      miss_entry();
      for (int c = 1; c <= 8; c++) begin
         #2;
         chk($sformatf("to_imiss_c%0d", c), {err, req}, 2'b01);
         @(negedge CLK);
      end
      #2;
      chk("err_outs", {err, pc_w, ifid_w, flush, bub, hold, req}, 7'b1000010);
      @(negedge CLK);
      ready = 1'b1;
      @(negedge CLK);
      ready = 1'b0;
      #2;
      chk("err_sticky", {err, pc_w}, 2'b10);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("err_async_clear", {err, hold}, 2'b00);
      @(negedge CLK);
      RESET = 1'b1;
      #2;
      chk("err_after_reset", {err, pc_w}, 2'b01);
      // ready coincident with timeout wins
      do_reset();
      miss_entry();
      for (int c = 1; c <= 8; c++) begin
         ready = c == 8;
         @(negedge CLK);
      end
      ready = 1'b0;
      #2;
      chk("ready_beats_timeout", {err, pc_w, req}, 3'b010);
      // reset in the middle of a refill drops the request immediately
      do_reset();
      miss_entry();
      #1;
      chk("midmiss_req", req, 1);
      RESET = 1'b0;
      #1;
      chk("midmiss_reset_req", req, 0);
      @(negedge CLK);
      RESET = 1'b1;
      #2;
      chk("midmiss_run", {pc_w, req}, 2'b10);
      // stall counter saturation at 4 bits
      do_reset();
      dstall = 1'b1;
      repeat (20) @(negedge CLK);
      dstall = 1'b0;
      #2;
      chk("stall_cnt_sat", cnt, 15);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
